// File: rtl/inertial_pkg.sv
// inertial_pkg: shared FSM states, sensor command words and read-address map for inertial_intf
package inertial_pkg;
  typedef enum logic [3:0] {
    PWR_UP = 4'd0, INIT1 = 4'd1, INIT2 = 4'd2, INIT3 = 4'd3, INIT4 = 4'd4,
    WAIT = 4'd5, RD_PL = 4'd6, RD_PH = 4'd7, RD_AL = 4'd8, RD_AH = 4'd9, VLD = 4'd10
  } state_t;
  localparam logic [15:0] INIT_CMD1 = 16'h0D02;
  localparam logic [15:0] INIT_CMD2 = 16'h1053;
  localparam logic [15:0] INIT_CMD3 = 16'h1150;
  localparam logic [15:0] INIT_CMD4 = 16'h1460;
  localparam logic [6:0] ADDR_PL = 7'h22;
  localparam logic [6:0] ADDR_PH = 7'h23;
  localparam logic [6:0] ADDR_AL = 7'h2C;
  localparam logic [6:0] ADDR_AH = 7'h2D;
  function automatic logic [15:0] cmd_of(input state_t s);
    return s == INIT1 ? INIT_CMD1 :
           s == INIT2 ? INIT_CMD2 :
           s == INIT3 ? INIT_CMD3 :
           s == INIT4 ? INIT_CMD4 :
           s == RD_PL ? {1'b1, ADDR_PL, 8'h00} :
           s == RD_PH ? {1'b1, ADDR_PH, 8'h00} :
           s == RD_AL ? {1'b1, ADDR_AL, 8'h00} :
           s == RD_AH ? {1'b1, ADDR_AH, 8'h00} : 16'h0000;
  endfunction
endpackage

// File: rtl/inertial_intf_spi.sv
// spi_mstr16: 16-bit SPI master, SCLK idle high, MOSI driven on falling edges, MISO sampled on rising
module spi_mstr16 #(
  parameter int SCLK_DIV_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  localparam int TW = SCLK_DIV_W + 5;
  // frame spans 33 half-periods: lead-in, 32 SCLK phases, then trailing half before SS_n rises
  localparam logic [TW-1:0] LAST = TW'(33 << (SCLK_DIV_W - 1));
  logic [TW-1:0] t, nxt;
  logic [15:0] tx;
  logic fin, rise, fall;
  assign nxt = t + 1'b1;
  assign fin = ~SS_n & (nxt == LAST);
  assign rise = ~SS_n & ~SCLK & ~nxt[SCLK_DIV_W-1];
  assign fall = ~SS_n & SCLK & nxt[SCLK_DIV_W-1] & (nxt[TW-1:SCLK_DIV_W] != '0);
  assign MOSI = tx[15];
  always_ff @(posedge clk) begin
    if (rst) begin
      SS_n <= 1'b1;
      SCLK <= 1'b1;
      tx <= '0;
      rd_data <= '0;
      t <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (SS_n) begin
        if (wrt) begin
          SS_n <= 1'b0;
          t <= '0;
          tx <= cmd;
        end
      end else begin
        t <= nxt;
        SCLK <= ~nxt[SCLK_DIV_W-1] | fin;
        SS_n <= fin;
      end
      if (rise) rd_data <= {rd_data[14:0], MISO};
      if (fall) tx <= {tx[14:0], 1'b0};
    end
  end
endmodule

// File: rtl/inertial_intf.sv
// inertial_intf: powers up and initialises the inertial sensor, then reads pitch rate and AZ on each data-ready
module inertial_intf
  import inertial_pkg::*;
#(
  parameter int PWR_UP_W = 16,
  parameter int SCLK_DIV_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);
  state_t state;
  logic [PWR_UP_W-1:0] timer;
  logic sent, int_ff, int_s, cmd_st, wrt, done, unused_hi;
  logic [15:0] rd_data;
  logic [7:0] pl, ph, al, ah;
  assign cmd_st = !(state inside {PWR_UP, WAIT, VLD});
  assign wrt = cmd_st & ~sent;
  assign unused_hi = ^rd_data[15:8];
  spi_mstr16 #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
    .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd_of(state)), .done(done), .rd_data(rd_data),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PWR_UP;
      timer <= '0;
      sent <= 1'b0;
      int_ff <= 1'b0;
      int_s <= 1'b0;
      {pl, ph, al, ah} <= '0;
      ptch_rt <= '0;
      AZ <= '0;
      vld <= 1'b0;
    end else begin
      int_ff <= INT;
      int_s <= int_ff;
      vld <= 1'b0;
      case (state)
        PWR_UP: begin
          timer <= timer + 1'b1;
          if (&timer) state <= INIT1;
        end
        WAIT: if (int_s) state <= RD_PL;
        VLD: begin
          ptch_rt <= {ph, pl};
          AZ <= {ah, al};
          vld <= 1'b1;
          state <= WAIT;
        end
        default: begin
          sent <= 1'b1;
          if (done) begin
            sent <= 1'b0;
            state <= state_t'(state + 4'd1);
            if (state == RD_PL) pl <= rd_data[7:0];
            if (state == RD_PH) ph <= rd_data[7:0];
            if (state == RD_AL) al <= rd_data[7:0];
            if (state == RD_AH) ah <= rd_data[7:0];
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inertial_intf.sv
// tb_inertial_intf: sensor slave model with frame/output scoreboards and SPI timing monitor
module tb_inertial_intf;
  logic clk = 1'b0, rst = 1'b1, INT = 1'b0, MISO = 1'b0;
  logic SS_n, SCLK, MOSI, vld;
  logic [15:0] ptch_rt, AZ;
  int checks = 0, errors = 0;
  logic [15:0] exp_f[$];
  logic [31:0] exp_o[$];
  logic [7:0] regmap [0:127];
  logic [15:0] srx = '0;
  logic [7:0] stx = '0;
  int nb = 0;
  logic auto_clr = 1'b0, aborting = 1'b1;
  logic prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
  logic [15:0] last_p = '0, last_a = '0;

  always #5 clk = ~clk;

  inertial_intf #(.PWR_UP_W(4), .SCLK_DIV_W(4)) dut (
    .clk(clk), .rst(rst), .INT(INT), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // sensor model: address in first byte, data byte shifted out in second byte
  always @(negedge SS_n) begin
    nb = 0;
    srx = '0;
    MISO = 1'b0;
    if (!aborting) check("frame_expected", 32'(exp_f.size() != 0), 1);
  end
  always @(posedge SCLK) if (!SS_n) begin
    srx = {srx[14:0], MOSI};
    nb++;
    if (nb == 8) begin
      stx = regmap[srx[6:0]];
      if (auto_clr && srx[7:0] == 8'hAD) INT = 1'b0;
    end
  end
  always @(negedge SCLK) if (!SS_n && nb >= 8) begin
    MISO = stx[7];
    stx = {stx[6:0], 1'b0};
  end
  always @(posedge SS_n) if (!aborting) begin
    check("frame_edges", nb, 16);
    if (exp_f.size() != 0) check("frame_word", srx, exp_f.pop_front());
  end

  always @(negedge clk) begin
    if (rst) begin
      last_p = '0;
      last_a = '0;
    end else begin
      if (vld) begin
        if (exp_o.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL vld_unexpected actual=%h required=none", {ptch_rt, AZ});
        end else check("vld_data", {ptch_rt, AZ}, exp_o.pop_front());
        last_p = ptch_rt;
        last_a = AZ;
      end else check("out_stable", {ptch_rt, AZ}, {last_p, last_a});
      if (SS_n) check("sclk_idle", SCLK, 1);
      if (SCLK && !prev_sclk) check("mosi_stable", MOSI, prev_mosi);
      if (SS_n !== prev_ss || dut.u_spi.done) check("done_at_ss_rise", dut.u_spi.done, SS_n & ~prev_ss);
    end
    prev_ss = SS_n;
    prev_sclk = SCLK;
    prev_mosi = MOSI;
  end

  task automatic reset_check();
    check("rst_SS_n", SS_n, 1);
    check("rst_SCLK", SCLK, 1);
    check("rst_MOSI", MOSI, 0);
    check("rst_vld", vld, 0);
    check("rst_ptch_rt", ptch_rt, 0);
    check("rst_AZ", AZ, 0);
  endtask

  task automatic push_init();
    exp_f.push_back(16'h0D02);
    exp_f.push_back(16'h1053);
    exp_f.push_back(16'h1150);
    exp_f.push_back(16'h1460);
  endtask

  task automatic push_read(input logic [7:0] b0, b1, b2, b3);
    regmap[7'h22] = b0;
    regmap[7'h23] = b1;
    regmap[7'h2C] = b2;
    regmap[7'h2D] = b3;
    exp_f.push_back(16'hA200);
    exp_f.push_back(16'hA300);
    exp_f.push_back(16'hAC00);
    exp_f.push_back(16'hAD00);
    exp_o.push_back({b1, b0, b3, b2});
  endtask

  task automatic pwr_check();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("pwrup_ss_high", SS_n, 1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_f.size() != 0 || exp_o.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_frames", exp_f.size(), 0);
    check("drain_vld", exp_o.size(), 0);
    exp_f.delete();
    exp_o.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) regmap[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset_check();
    push_init();
    aborting = 1'b0;
    rst = 1'b0;
    pwr_check();
    wait_idle(3000);
    repeat (60) @(negedge clk);
    check("idle_after_init", SS_n, 1);
    // basic read sequence
    push_read(8'h34, 8'h12, 8'hCD, 8'hAB);
    auto_clr = 1'b1;
    INT = 1'b1;
    wait_idle(5000);
    repeat (100) @(negedge clk);
    // INT glitching during RD_AL must not add frames
    push_read(8'h11, 8'h22, 8'h33, 8'h44);
    INT = 1'b1;
    n = 0;
    while (exp_f.size() > 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (60) @(negedge clk);
    INT = 1'b0;
    repeat (3) @(negedge clk);
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    repeat (3) @(negedge clk);
    INT = 1'b1;
    wait_idle(5000);
    repeat (100) @(negedge clk);
    // INT held high through VLD: back-to-back sequences
    auto_clr = 1'b0;
    push_read(8'h5A, 8'hA5, 8'h01, 8'h7F);
    push_read(8'h5A, 8'hA5, 8'h01, 8'h7F);
    INT = 1'b1;
    n = 0;
    while (!vld && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_vld_seen", vld, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (SS_n && n < 10);
    check("b2b_gap", n, 2);
    auto_clr = 1'b1;
    wait_idle(5000);
    repeat (100) @(negedge clk);
    // reset in the middle of the RD_PH frame
    exp_f.push_back(16'hA200);
    INT = 1'b1;
    n = 0;
    while (exp_f.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    aborting = 1'b1;
    n = 0;
    while (SS_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ph_frame_started", SS_n, 0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    INT = 1'b0;
    @(negedge clk);
    reset_check();
    repeat (2) @(negedge clk);
    exp_f.delete();
    exp_o.delete();
    aborting = 1'b0;
    push_init();
    rst = 1'b0;
    pwr_check();
    wait_idle(3000);
    repeat (60) @(negedge clk);
    // extreme raw values pass through unmodified
    push_read(8'hFF, 8'h80, 8'h00, 8'h80);
    INT = 1'b1;
    wait_idle(5000);
    repeat (50) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
